// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute-stage ALU.
// Holds the 4-bit ALU operation codes that the ALU-control decoder emits and
// this stage consumes, plus the default datapath and register-index widths.
package mips_alu_pkg;

    // Default widths for the EX stage.
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;

    // ALU operation codes. The decoder uses these same constants.
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_SLL = 4'd13;
    localparam logic [3:0] ALU_SRL = 4'd14;
    localparam logic [3:0] ALU_ILL = 4'd15;

endpackage

// File: rtl/alu_core.sv
// Purely combinational MIPS ALU.
// Ports:
//   alu_control  - 4-bit operation code (see mips_alu_pkg)
//   unsigned_num - 1: no overflow on add/sub, unsigned compare on slt
//   src_a/src_b  - operands; shifts act on src_b
//   shamt        - shift amount for sll/srl
//   result       - ALU result (0 for illegal codes)
//   zero         - result == 0
//   ovf          - signed overflow on add/sub (only when unsigned_num = 0)
//   illegal      - alu_control is not a defined operation
module alu_core
    import mips_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        alu_control,
    input  logic              unsigned_num,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf,
    output logic              illegal
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              a_msb;
    logic              b_msb;
    logic              lt;

    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;
    assign a_msb = src_a[DATA_W-1];
    assign b_msb = src_b[DATA_W-1];
    assign lt    = unsigned_num ? (src_a < src_b) : ($signed(src_a) < $signed(src_b));

    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (alu_control)
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_NOR: result = ~(src_a | src_b);
            ALU_ADD: begin
                result = sum;
                // Same-sign operands producing a different-sign sum.
                ovf    = !unsigned_num && (a_msb == b_msb) && (sum[DATA_W-1] != a_msb);
            end
            ALU_SUB: begin
                result = diff;
                // Opposite-sign operands where the difference flips away from src_a.
                ovf    = !unsigned_num && (a_msb != b_msb) && (diff[DATA_W-1] != a_msb);
            end
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
            ALU_SLL: result = src_b << shamt;
            ALU_SRL: result = src_b >> shamt;
            ALU_ILL: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: ALU plus EX/MEM pipeline register behind valid/ready.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake; in_ready = !out_valid || out_ready
//   alu_control         - operation code from the ALU-control decoder
//   unsigned_num        - suppresses overflow, selects unsigned slt
//   src_a, src_b, shamt - operands and shift amount
//   dst_reg, wr_en      - write-back destination and enable
//   flush               - kills the held and the same-cycle incoming instruction
//   out_valid/out_ready - downstream handshake
//   out_result, out_zero, out_dst_reg, out_wr_en, out_ovf, out_illegal
//                       - registered EX/MEM fields; out_wr_en masked on exceptions
module ex_alu_stage
    import mips_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic              unsigned_num,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [4:0]        shamt,
    input  logic [REG_W-1:0]  dst_reg,
    input  logic              wr_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [REG_W-1:0]  out_dst_reg,
    output logic              out_wr_en,
    output logic              out_ovf,
    output logic              out_illegal
);

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_ovf;
    logic              alu_illegal;
    logic              accept;

    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic [REG_W-1:0]  dst_q;
    logic              wr_en_q;
    logic              ovf_q;
    logic              illegal_q;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .alu_control  (alu_control),
        .unsigned_num (unsigned_num),
        .src_a        (src_a),
        .src_b        (src_b),
        .shamt        (shamt),
        .result       (alu_result),
        .zero         (alu_zero),
        .ovf          (alu_ovf),
        .illegal      (alu_illegal)
    );

    // Combinational from out_ready so a streaming pipe never bubbles.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            dst_q     <= '0;
            wr_en_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            // Drops both the held entry and any same-cycle input.
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            result_q  <= alu_result;
            zero_q    <= alu_zero;
            dst_q     <= dst_reg;
            wr_en_q   <= wr_en && !alu_ovf && !alu_illegal;
            ovf_q     <= alu_ovf;
            illegal_q <= alu_illegal;
        end else if (out_ready) begin
            // Drain: only the valid bit changes, data fields keep their values.
            valid_q   <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_dst_reg = dst_q;
    assign out_wr_en   = wr_en_q;
    assign out_ovf     = ovf_q;
    assign out_illegal = illegal_q;

endmodule
